// File: rtl/sobel_scan_ctrl_if.sv
// Handshake bundle between the Sobel scan sequencer and its host/datapath.
// master: sequencer side; slave: frame controller / downstream side.
interface sobel_scan_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              Start;
  logic              OutReady;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic              ShiftEn;
  logic              LineStart;
  logic              WinValid;
  logic [ADDR_W-1:0] WrAddr;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, OutReady,
    output RdEn, RdAddr, ShiftEn, LineStart, WinValid, WrAddr, Busy, Done
  );

  modport slave (
    output Start, OutReady,
    input  RdEn, RdAddr, ShiftEn, LineStart, WinValid, WrAddr, Busy, Done
  );
endinterface

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan sequencer for the Sobel pipeline: issues one source read per cycle,
// drives line-buffer shift/window-valid strobes one cycle later, and pulses Done.
module sobel_scan_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int COL_W  = 8,
  parameter int ROW_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  sobel_scan_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] WIN_OFS  = ADDR_W'(IMG_W + 1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic              shift_en;
  logic              line_start;
  logic              win_valid;
  logic              busy;
  logic              done;

  // Read strobe follows OutReady without a register so a stall takes effect at once.
  assign rd_en = (state == READ) && bus.OutReady;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      shift_en   <= 1'b0;
      line_start <= 1'b0;
      win_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      shift_en   <= rd_en;
      line_start <= rd_en && (col == '0);
      win_valid  <= rd_en && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      if (rd_en) wr_addr <= rd_addr - WIN_OFS;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Start) begin
            state   <= READ;
            busy    <= 1'b1;
            col     <= '0;
            row     <= '0;
            rd_addr <= '0;
          end
        end
        READ: begin
          if (rd_en) begin
            // Counters park on the last pixel rather than stepping past the frame.
            if ((col == COL_LAST) && (row == ROW_LAST)) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RdEn      = rd_en;
  assign bus.RdAddr    = rd_addr;
  assign bus.ShiftEn   = shift_en;
  assign bus.LineStart = line_start;
  assign bus.WinValid  = win_valid;
  assign bus.WrAddr    = wr_addr;
  assign bus.Busy      = busy;
  assign bus.Done      = done;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Directed bench for sobel_scan_ctrl on a 4x4 frame: full frames, stall,
// ignored restart, async abort and back-to-back frames.
module tb_sobel_scan_ctrl;

  logic CLK = 1'b0;
  logic Reset;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  sobel_scan_ctrl_if #(.ADDR_W(4)) bus ();

  sobel_scan_ctrl #(
    .IMG_W (4),
    .IMG_H (4),
    .COL_W (2),
    .ROW_W (2),
    .ADDR_W(4)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rden"},  bus.RdEn,      0);
    chk({tag, "_rdaddr"}, bus.RdAddr,   0);
    chk({tag, "_shift"}, bus.ShiftEn,   0);
    chk({tag, "_lstart"}, bus.LineStart, 0);
    chk({tag, "_win"},   bus.WinValid,  0);
    chk({tag, "_wraddr"}, bus.WrAddr,   0);
    chk({tag, "_busy"},  bus.Busy,      0);
    chk({tag, "_done"},  bus.Done,      0);
  endtask

  // One frame: Start in cycle 0; optional 3-cycle-style stall before address 9,
  // optional Start re-pulse, optional reset abort at a given read address.
  task automatic run_frame(input int stall_len, input int restart_at,
                           input int abort_addr, input int tail);
    int exp_rd = 0, wins = 0, busy_cyc = 0, dones = 0;
    int last_rd = -1, done_cyc = -1, stall_left, pend_addr = 0;
    bit pend = 0, seen_done = 0, exp_rden, exp_win;
    stall_left = stall_len;
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      @(posedge CLK); #1;
      bus.Start = (cyc == 0) || (cyc == restart_at);
      if (exp_rd == 9 && stall_left > 0) begin
        bus.OutReady = 1'b0;
        stall_left--;
      end else begin
        bus.OutReady = 1'b1;
      end
      @(negedge CLK);
      if (cyc == 0) chk("busy_pre", bus.Busy, 0);
      if (bus.Busy) busy_cyc++;
      chk("shift", bus.ShiftEn, pend);
      if (pend) begin
        exp_win = (pend_addr / 4 >= 2) && (pend_addr % 4 >= 2);
        chk("linestart", bus.LineStart, (pend_addr % 4) == 0);
        chk("winvalid", bus.WinValid, exp_win);
        if (exp_win) chk("wraddr", bus.WrAddr, pend_addr - 5);
      end
      if (bus.WinValid) wins++;
      exp_rden = (cyc >= 1) && (exp_rd < 16) && bus.OutReady;
      chk("rden", bus.RdEn, exp_rden);
      if (!bus.OutReady && cyc >= 1 && exp_rd < 16) chk("frozen", bus.RdAddr, exp_rd);
      pend = bus.RdEn;
      if (bus.RdEn) begin
        chk("rdaddr", bus.RdAddr, exp_rd);
        pend_addr = exp_rd;
        exp_rd++;
        last_rd = cyc;
        if (pend_addr == abort_addr) begin
          Reset = 1'b1;
          #1;
          chk_all_zero("abort");
          @(negedge CLK);
          @(negedge CLK);
          Reset = 1'b0;
          bus.Start = 1'b0;
          @(negedge CLK);
          chk("idle_busy", bus.Busy, 0);
          chk("idle_rden", bus.RdEn, 0);
          return;
        end
      end
      if (bus.Done) begin
        dones++;
        done_cyc  = cyc;
        seen_done = 1'b1;
      end
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    chk("reads", exp_rd, 16);
    chk("wins", wins, 4);
    chk("dones", dones, 1);
    chk("done_lag", done_cyc - last_rd, 2);
    chk("busy_span", busy_cyc, 18 + stall_len);
    for (int t = 0; t < tail; t++) begin
      @(posedge CLK); #1;
      bus.Start = 1'b0;
      @(negedge CLK);
      chk("tail_done", bus.Done, 0);
      chk("tail_busy", bus.Busy, 0);
    end
  endtask

  initial begin
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.OutReady = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    run_frame(0, -1, -1, 2);   // plain frame
    run_frame(3, -1, -1, 2);   // stall mid-row 2
    run_frame(0, 5, -1, 4);    // Start re-pulsed during READ
    run_frame(0, -1, 7, 0);    // async abort at address 7
    run_frame(0, -1, -1, 0);   // clean frame after abort
    run_frame(0, -1, -1, 2);   // back-to-back: Start in cycle after Done

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
